// File: rtl/axi_slave_ram_pkg.sv
// Shared encodings for the AXI4 slave RAM: burst types, response codes and FSM states.
package axi_slave_ram_pkg;

  localparam logic [1:0] BurstFixed = 2'b00;
  localparam logic [1:0] BurstIncr  = 2'b01;
  localparam logic [1:0] BurstWrap  = 2'b10;

  localparam logic [1:0] RespOkay   = 2'b00;
  localparam logic [1:0] RespSlverr = 2'b10;

  typedef enum logic [1:0] {
    StIdle   = 2'b00,
    StWrData = 2'b01,
    StWrResp = 2'b10,
    StRdData = 2'b11
  } state_e;

  // Beats wider than the data bus are treated as full-width beats.
  function automatic logic [2:0] clamp_size(input logic [2:0] size, input logic [2:0] max_size);
    return (size > max_size) ? max_size : size;
  endfunction

endpackage

// File: rtl/sp_ram_bytewe.sv
// Single-port synchronous RAM with per-byte write enables and a registered read port.
module sp_ram_bytewe #(
  parameter int unsigned DATA_WIDTH = 64,
  parameter int unsigned DEPTH      = 4096
) (
  input  logic                       clk_i,
  input  logic                       en_i,
  input  logic [DATA_WIDTH/8-1:0]    we_i,
  input  logic [$clog2(DEPTH)-1:0]   addr_i,
  input  logic [DATA_WIDTH-1:0]      din_i,
  output logic [DATA_WIDTH-1:0]      dout_o
);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [DATA_WIDTH-1:0] dout_q;

  // Read-first access; dout holds its value whenever the RAM is not enabled.
  always_ff @(posedge clk_i) begin
    if (en_i) begin
      for (int unsigned b = 0; b < DATA_WIDTH / 8; b++) begin
        if (we_i[b]) begin
          mem_q[addr_i][b*8 +: 8] <= din_i[b*8 +: 8];
        end
      end
      dout_q <= mem_q[addr_i];
    end
  end

  assign dout_o = dout_q;

endmodule

// File: rtl/axi_slave_ram.sv
// AXI4 slave memory: one burst at a time, round-robin between write and read requests.
module axi_slave_ram
  import axi_slave_ram_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 64,
  parameter int unsigned ID_WIDTH   = 4,
  parameter int unsigned DEPTH      = 4096
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic [ID_WIDTH-1:0]     awid_i,
  input  logic [ADDR_WIDTH-1:0]   awaddr_i,
  input  logic [7:0]              awlen_i,
  input  logic [2:0]              awsize_i,
  input  logic [1:0]              awburst_i,
  input  logic                    awvalid_i,
  output logic                    awready_o,
  input  logic [DATA_WIDTH-1:0]   wdata_i,
  input  logic [DATA_WIDTH/8-1:0] wstrb_i,
  input  logic                    wlast_i,
  input  logic                    wvalid_i,
  output logic                    wready_o,
  output logic [ID_WIDTH-1:0]     bid_o,
  output logic [1:0]              bresp_o,
  output logic                    bvalid_o,
  input  logic                    bready_i,
  input  logic [ID_WIDTH-1:0]     arid_i,
  input  logic [ADDR_WIDTH-1:0]   araddr_i,
  input  logic [7:0]              arlen_i,
  input  logic [2:0]              arsize_i,
  input  logic [1:0]              arburst_i,
  input  logic                    arvalid_i,
  output logic                    arready_o,
  output logic [ID_WIDTH-1:0]     rid_o,
  output logic [DATA_WIDTH-1:0]   rdata_o,
  output logic [1:0]              rresp_o,
  output logic                    rlast_o,
  output logic                    rvalid_o,
  input  logic                    rready_i
);

  localparam int unsigned StrbW   = DATA_WIDTH / 8;
  localparam int unsigned OffW    = $clog2(StrbW);
  localparam int unsigned IdxW    = $clog2(DEPTH);
  localparam logic [2:0]  MaxSize = 3'(OffW);

  state_e                  state_q, state_d;
  logic                    prio_wr_q, prio_wr_d;
  logic [ID_WIDTH-1:0]     id_q, id_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d, addr_nxt;
  logic [7:0]              len_q, len_d;
  logic [2:0]              size_q, size_d;
  logic [1:0]              burst_q, burst_d;
  logic                    aw_grant, ar_grant;

  logic                    ram_en;
  logic [StrbW-1:0]        ram_we;
  logic [IdxW-1:0]         ram_addr;

  // Address of the following beat; WRAP is handled like INCR.
  always_comb begin
    addr_nxt = addr_q;
    if (burst_q != BurstFixed) begin
      addr_nxt = addr_q + (ADDR_WIDTH'(1) << size_q);
    end
  end

  // Request arbitration in IDLE: prio_wr decides only when both directions are requesting.
  always_comb begin
    aw_grant = 1'b0;
    ar_grant = 1'b0;
    if (state_q == StIdle) begin
      aw_grant = awvalid_i & (~arvalid_i | prio_wr_q);
      ar_grant = arvalid_i & (~awvalid_i | ~prio_wr_q);
    end
  end

  // Next-state, channel handshakes and RAM control.
  always_comb begin
    state_d   = state_q;
    prio_wr_d = prio_wr_q;
    id_d      = id_q;
    addr_d    = addr_q;
    len_d     = len_q;
    size_d    = size_q;
    burst_d   = burst_q;
    wready_o  = 1'b0;
    bvalid_o  = 1'b0;
    rvalid_o  = 1'b0;
    rlast_o   = 1'b0;
    ram_en    = 1'b0;
    ram_we    = '0;
    ram_addr  = addr_q[IdxW+OffW-1:OffW];

    unique case (state_q)
      StIdle: begin
        if (aw_grant) begin
          id_d    = awid_i;
          addr_d  = awaddr_i;
          len_d   = awlen_i;
          size_d  = clamp_size(awsize_i, MaxSize);
          burst_d = awburst_i;
          state_d = StWrData;
        end else if (ar_grant) begin
          id_d     = arid_i;
          addr_d   = araddr_i;
          len_d    = arlen_i;
          size_d   = clamp_size(arsize_i, MaxSize);
          burst_d  = arburst_i;
          // First beat is fetched now so rdata is ready the next cycle.
          ram_en   = 1'b1;
          ram_addr = araddr_i[IdxW+OffW-1:OffW];
          state_d  = StRdData;
        end
      end
      StWrData: begin
        wready_o = 1'b1;
        if (wvalid_i) begin
          ram_en = 1'b1;
          ram_we = wstrb_i;
          addr_d = addr_nxt;
          if (wlast_i) begin
            state_d = StWrResp;
          end
        end
      end
      StWrResp: begin
        bvalid_o = 1'b1;
        if (bready_i) begin
          prio_wr_d = 1'b0;
          state_d   = StIdle;
        end
      end
      StRdData: begin
        rvalid_o = 1'b1;
        rlast_o  = (len_q == 8'd0);
        if (rready_i) begin
          if (len_q == 8'd0) begin
            prio_wr_d = 1'b1;
            state_d   = StIdle;
          end else begin
            ram_en   = 1'b1;
            ram_addr = addr_nxt[IdxW+OffW-1:OffW];
            addr_d   = addr_nxt;
            len_d    = len_q - 8'd1;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Transaction state registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= StIdle;
      prio_wr_q <= 1'b1;
      id_q      <= '0;
      addr_q    <= '0;
      len_q     <= '0;
      size_q    <= '0;
      burst_q   <= '0;
    end else begin
      state_q   <= state_d;
      prio_wr_q <= prio_wr_d;
      id_q      <= id_d;
      addr_q    <= addr_d;
      len_q     <= len_d;
      size_q    <= size_d;
      burst_q   <= burst_d;
    end
  end

  sp_ram_bytewe #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH)
  ) u_ram (
    .clk_i  (clk_i),
    .en_i   (ram_en),
    .we_i   (ram_we),
    .addr_i (ram_addr),
    .din_i  (wdata_i),
    .dout_o (rdata_o)
  );

  assign awready_o = aw_grant;
  assign arready_o = ar_grant;
  assign bid_o     = id_q;
  assign rid_o     = id_q;
  assign bresp_o   = RespOkay;
  assign rresp_o   = RespOkay;

endmodule

// File: doc/axi_slave_ram.md
Name: axi_slave_ram

Overview:
- AXI4 slave (responder) memory: the subordinate end of the bus driven by axi_core_mem.
- In-house replacement for the vendor block-RAM IP, so simulation and non-Xilinx flows need no vendor models.
- Serves both the instruction-fetch and load/store traffic of the pipeline core through one AXI4 port.
- Backing store is a single-port, byte-write-enable synchronous RAM; one transaction at a time.

Parameters:
- ADDR_WIDTH, 32, width of awaddr/araddr.
- DATA_WIDTH, 64, width of wdata/rdata; must be a power of two, >= 32.
- ID_WIDTH, 4, width of awid/arid/bid/rid.
- DEPTH, 4096, number of DATA_WIDTH-bit words; must be a power of two.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous reset, active low
- awid  in  ID_WIDTH  write ID
- awaddr  in  ADDR_WIDTH  write start byte address
- awlen  in  8  beats minus 1
- awsize  in  3  log2 bytes per beat
- awburst  in  2  burst type
- awvalid  in  1  AW valid
- awready  out  1  AW ready
- wdata  in  DATA_WIDTH  write data
- wstrb  in  DATA_WIDTH/8  byte strobes
- wlast  in  1  final write beat
- wvalid  in  1  W valid
- wready  out  1  W ready
- bid  out  ID_WIDTH  response ID
- bresp  out  2  write response
- bvalid  out  1  B valid
- bready  in  1  B ready
- arid, araddr, arlen, arsize, arburst, arvalid  in  as the AW group  read address channel
- arready  out  1  AR ready
- rid  out  ID_WIDTH  read ID
- rdata  out  DATA_WIDTH  read data
- rresp  out  2  read response
- rlast  out  1  final read beat
- rvalid  out  1  R valid
- rready  in  1  R ready

Behaviour:
- Clock and reset: single clock clk; rst_n asynchronous, active low.
- Reset values: FSM returns to IDLE. All of awready, wready, bvalid, arready, rvalid, rlast are 0. bid, rid, bresp, rresp are 0. Priority flag is set to write. RAM contents are not reset.
- Reset mid-burst: the burst is abandoned and no B or R response is issued for it.
- FSM states:
  - IDLE
  - WR_DATA
  - WR_RESP
  - RD_DATA
- IDLE:
  - awready = awvalid & (~arvalid | prio_wr).
  - arready = arvalid & (~awvalid | ~prio_wr).
  - These are combinational; both are 0 in every other state.
  - AW handshake captures ID, address, len, size and burst, then goes to WR_DATA.
  - AR handshake captures the same fields, issues the first RAM read in the same cycle, then goes to RD_DATA.
- Arbitration: prio_wr toggles at the end of every burst to the opposite direction, giving round-robin fairness when awvalid and arvalid are both held.
- WR_DATA:
  - wready = 1.
  - Each W handshake writes the RAM word selected by the current address, with byte enables = wstrb.
  - The address then advances.
  - The handshake carrying wlast goes to WR_RESP. The burst ends on wlast, not on a beat count.
- WR_RESP:
  - bvalid = 1, bid = captured ID, bresp = OKAY (2'b00).
  - On bready, go to IDLE.
- RD_DATA:
  - rvalid = 1; rdata is taken directly from the registered RAM output; rid = captured ID; rresp = OKAY.
  - rlast = 1 when the remaining-beat counter is 0.
  - On an R handshake that is not the last beat, the next address is read in the same cycle, so throughput is one beat per cycle while rready stays high.
  - While rready is low, the RAM read enable is low, so rdata is held stable.
  - On the handshake of the last beat, go to IDLE.
- Latency:
  - AR handshake to first rvalid: 1 cycle.
  - W last-beat handshake to bvalid: 1 cycle.
  - Minimum turnaround between bursts: 1 cycle in IDLE.
- Address arithmetic:
  - Word index = addr[log2(DEPTH)+log2(DATA_WIDTH/8)-1 : log2(DATA_WIDTH/8)]. Higher address bits are ignored, so accesses wrap modulo the memory size.
  - INCR: address += 2^size per beat.
  - FIXED: address is unchanged.
  - WRAP: treated as INCR.
  - size larger than the bus width is clamped to the bus width.
  - Narrow transfers rely on wstrb for writes and on the master's lane selection for reads.
- Error responses: never generated.

Decomposition:
- define.v: add macros for the burst encodings (FIXED 2'b00, INCR 2'b01, WRAP 2'b10), the response codes (OKAY 2'b00, SLVERR 2'b10), and the FSM state encodings.
- Reuse `BUS_AXI_STRB for the strobe width.
- Sub-module sp_ram_bytewe: single-port synchronous RAM with en, we[DATA_WIDTH/8-1:0], addr, din, and a registered dout that holds its value when en = 0.

Test Plan:
- Single write then read: AW addr 0x10, len 0, size 3, wdata 0x1122334455667788, wstrb 0xFF; then AR at the same address -> bvalid with bresp 0; rdata 0x1122334455667788, rlast = 1, rvalid one cycle after the AR handshake.
- Byte-strobe merge: write 0xFFFF_FFFF_FFFF_FFFF, then write 0 with wstrb 0x0F, then read -> 0xFFFFFFFF00000000.
- INCR burst with back-pressure: 4-beat write of 1, 2, 3, 4 at 0x100; read burst with rready toggling 1,0,1,0 -> rdata 1, 2, 3, 4 with no beat lost or repeated, rdata stable while rready = 0, rlast only on beat 4.
- Simultaneous requests: awvalid and arvalid asserted in the same cycle after reset -> write granted first, read second; repeat -> grant order alternates.
- FIXED burst: len 3 to 0x200 with data A, B, C, D -> a single read of 0x200 returns D.
- Reset mid-burst: assert rst_n = 0 during beat 2 of a 4-beat read -> rvalid = 0 and the FSM is in IDLE immediately; a following write/read pair completes correctly and earlier RAM contents are preserved.
